// File: rtl/rx_ctrl_pkg.sv
// rx_ctrl_pkg: shared mode codes, state encoding and mode validation for the Rx acquisition controller
package rx_ctrl_pkg;
   localparam logic [3:0] MODE_BPSK = 4'b0001;
   localparam logic [3:0] MODE_QPSK = 4'b0010;
   localparam logic [3:0] MODE_MIX  = 4'b0100;
   typedef enum logic [2:0] {
      ST_IDLE   = 3'd0,
      ST_SETTLE = 3'd1,
      ST_ACQ    = 3'd2,
      ST_TRACK  = 3'd3,
      ST_FAIL   = 3'd4
   } state_e;
   function automatic logic is_valid_mode(input logic [3:0] m);
      return m == MODE_BPSK || m == MODE_QPSK || m == MODE_MIX;
   endfunction
endpackage

// File: rtl/sat_counter.sv
// sat_counter: saturating up-counter with clear priority and terminal-count flag
module sat_counter #(
   parameter int W = 8,
   parameter logic [W-1:0] MAX = '1
) (
   input  logic clk_i,
   input  logic rst_i,
   input  logic inc_i,
   input  logic clr_i,
   output logic tc_o
);
   logic [W-1:0] cnt_q;
   // clear wins over increment; holds at MAX instead of wrapping
   always_ff @(posedge clk_i or posedge rst_i)
      if (rst_i) cnt_q <= '0;
      else if (clr_i) cnt_q <= '0;
      else if (inc_i && cnt_q != MAX) cnt_q <= cnt_q + 1'b1;
   assign tc_o = cnt_q == MAX;
endmodule

// File: rtl/rx_acq_ctrl.sv
// rx_acq_ctrl: acquisition/tracking sequencer owning Rx mode and loop-bandwidth configuration
module rx_acq_ctrl import rx_ctrl_pkg::*; #(
   parameter int SETTLE_CYC  = 256,
   parameter int LOCK_CNT    = 64,
   parameter int LOSS_CNT    = 128,
   parameter int ACQ_TIMEOUT = 16384,
   parameter int MAX_RETRY   = 3,
   parameter int ACQ_SHIFT   = 2,
   parameter int TRK_SHIFT   = 4
) (
   input  logic       clk_16M384,
   input  logic       rst_16M384,
   input  logic [3:0] mode_req,
   input  logic       mode_req_vld,
   output logic       mode_req_rdy,
   input  logic       sig_det,
   input  logic       pd_lock,
   output logic [3:0] MODE_CTRL,
   output logic [3:0] FEEDBACK_SHIFT,
   output logic [3:0] GARDNER_SHIFT,
   output logic       loop_rst,
   output logic       bd_en,
   output logic [2:0] state,
   output logic       mode_err
);
   localparam int M1 = SETTLE_CYC > LOCK_CNT ? SETTLE_CYC : LOCK_CNT;
   localparam int M2 = LOSS_CNT > ACQ_TIMEOUT ? LOSS_CNT : ACQ_TIMEOUT;
   localparam int M3 = M1 > M2 ? M1 : M2;
   localparam int MP = M3 > MAX_RETRY ? M3 : MAX_RETRY;
   localparam int CW = $clog2(MP) + 1;
   state_e state_q, state_d;
   logic [3:0] mode_q, mode_d, shift_q, shift_d;
   logic loop_rst_q, loop_rst_d, bd_en_q, bd_en_d, rdy_q, rdy_d, err_q, err_d;
   logic acc, acc_ok, tmo_evt;
   logic set_tc, lock_tc, loss_tc, tmo_tc, ret_tc;
   // settle: exactly SETTLE_CYC cycles, so terminal one short of the count
   sat_counter #(.W(CW), .MAX(CW'(SETTLE_CYC - 1))) u_settle (
      .clk_i(clk_16M384), .rst_i(rst_16M384),
      .inc_i(state_q == ST_SETTLE), .clr_i(state_d != ST_SETTLE), .tc_o(set_tc));
   sat_counter #(.W(CW), .MAX(CW'(LOCK_CNT))) u_lock (
      .clk_i(clk_16M384), .rst_i(rst_16M384),
      .inc_i(state_q == ST_ACQ && pd_lock), .clr_i(state_d != ST_ACQ || !pd_lock), .tc_o(lock_tc));
   sat_counter #(.W(CW), .MAX(CW'(LOSS_CNT))) u_loss (
      .clk_i(clk_16M384), .rst_i(rst_16M384),
      .inc_i(state_q == ST_TRACK && !pd_lock), .clr_i(state_d != ST_TRACK || pd_lock), .tc_o(loss_tc));
   // attempt timer: at most ACQ_TIMEOUT cycles spent in ACQ per attempt
   sat_counter #(.W(CW), .MAX(CW'(ACQ_TIMEOUT - 1))) u_tmo (
      .clk_i(clk_16M384), .rst_i(rst_16M384),
      .inc_i(state_q == ST_ACQ), .clr_i(state_d != ST_ACQ), .tc_o(tmo_tc));
   sat_counter #(.W(CW), .MAX(CW'(MAX_RETRY))) u_retry (
      .clk_i(clk_16M384), .rst_i(rst_16M384),
      .inc_i(tmo_evt), .clr_i(state_q == ST_IDLE || acc_ok), .tc_o(ret_tc));
   // next state with priority signal loss > mode request > lock/loss/timeout; outputs follow next state
   always_comb begin
      acc = mode_req_vld && rdy_q;
      acc_ok = acc && is_valid_mode(mode_req);
      tmo_evt = 1'b0;
      state_d = state_q;
      if (!sig_det) state_d = ST_IDLE;
      else if (acc_ok) state_d = ST_SETTLE;
      else
         case (state_q)
            ST_IDLE:   state_d = ST_SETTLE;
            ST_SETTLE: state_d = set_tc ? ST_ACQ : ST_SETTLE;
            ST_ACQ:
               if (lock_tc) state_d = ST_TRACK;
               else if (tmo_tc) begin
                  tmo_evt = 1'b1;
                  state_d = ret_tc ? ST_FAIL : ST_SETTLE;
               end
            ST_TRACK:  state_d = loss_tc ? ST_ACQ : ST_TRACK;
            default:   state_d = state_q;
         endcase
      mode_d = acc_ok ? mode_req : mode_q;
      err_d = acc && !is_valid_mode(mode_req);
      loop_rst_d = state_d != ST_ACQ && state_d != ST_TRACK;
      bd_en_d = state_d == ST_TRACK;
      shift_d = state_d == ST_TRACK ? 4'(TRK_SHIFT) : 4'(ACQ_SHIFT);
      rdy_d = state_d != ST_SETTLE;
   end
   // state and output registers
   always_ff @(posedge clk_16M384 or posedge rst_16M384)
      if (rst_16M384) begin
         state_q    <= ST_IDLE;
         mode_q     <= MODE_BPSK;
         shift_q    <= 4'(ACQ_SHIFT);
         loop_rst_q <= 1'b1;
         bd_en_q    <= 1'b0;
         rdy_q      <= 1'b1;
         err_q      <= 1'b0;
      end else begin
         state_q    <= state_d;
         mode_q     <= mode_d;
         shift_q    <= shift_d;
         loop_rst_q <= loop_rst_d;
         bd_en_q    <= bd_en_d;
         rdy_q      <= rdy_d;
         err_q      <= err_d;
      end
   assign state          = state_q;
   assign MODE_CTRL      = mode_q;
   assign FEEDBACK_SHIFT = shift_q;
   assign GARDNER_SHIFT  = shift_q;
   assign loop_rst       = loop_rst_q;
   assign bd_en          = bd_en_q;
   assign mode_req_rdy   = rdy_q;
   assign mode_err       = err_q;
endmodule

// File: tb/tb_rx_acq_ctrl.sv
// tb_rx_acq_ctrl: directed scenario bench for rx_acq_ctrl with default parameters
module tb_rx_acq_ctrl;
   logic clk = 1'b0;
   logic rst = 1'b1;
   logic [3:0] mode_req = 4'b0000;
   logic mode_req_vld = 1'b0;
   logic sig_det = 1'b1;
   logic pd_lock = 1'b1;
   logic mode_req_rdy, loop_rst, bd_en, mode_err;
   logic [3:0] MODE_CTRL, FEEDBACK_SHIFT, GARDNER_SHIFT;
   logic [2:0] state;
   int n_cmp = 0;
   int n_bad = 0;
   // observed vector: state, mode, feedback shift, gardner shift, loop_rst, bd_en, rdy, mode_err
   logic [18:0] obs, want;
   assign obs = {state, MODE_CTRL, FEEDBACK_SHIFT, GARDNER_SHIFT, loop_rst, bd_en, mode_req_rdy, mode_err};
   localparam logic [18:0] V_RESET   = {3'd0, 4'b0001, 4'd2, 4'd2, 4'b1010};
   localparam logic [18:0] V_SET_B   = {3'd1, 4'b0001, 4'd2, 4'd2, 4'b1000};
   localparam logic [18:0] V_ACQ_B   = {3'd2, 4'b0001, 4'd2, 4'd2, 4'b0010};
   localparam logic [18:0] V_TRK_B   = {3'd3, 4'b0001, 4'd4, 4'd4, 4'b0110};
   localparam logic [18:0] V_TRK_ERR = {3'd3, 4'b0001, 4'd4, 4'd4, 4'b0111};
   localparam logic [18:0] V_FAIL_B  = {3'd4, 4'b0001, 4'd2, 4'd2, 4'b1010};
   localparam logic [18:0] V_SET_Q   = {3'd1, 4'b0010, 4'd2, 4'd2, 4'b1000};
   localparam logic [18:0] V_ACQ_Q   = {3'd2, 4'b0010, 4'd2, 4'd2, 4'b0010};
   localparam logic [18:0] V_IDLE_M  = {3'd0, 4'b0100, 4'd2, 4'd2, 4'b1010};
   localparam logic [18:0] V_SET_M   = {3'd1, 4'b0100, 4'd2, 4'd2, 4'b1000};
   localparam logic [18:0] V_ACQ_M   = {3'd2, 4'b0100, 4'd2, 4'd2, 4'b0010};
   localparam logic [18:0] V_TRK_M   = {3'd3, 4'b0100, 4'd4, 4'd4, 4'b0110};
   rx_acq_ctrl dut (
      .clk_16M384(clk), .rst_16M384(rst),
      .mode_req(mode_req), .mode_req_vld(mode_req_vld), .mode_req_rdy(mode_req_rdy),
      .sig_det(sig_det), .pd_lock(pd_lock),
      .MODE_CTRL(MODE_CTRL), .FEEDBACK_SHIFT(FEEDBACK_SHIFT), .GARDNER_SHIFT(GARDNER_SHIFT),
      .loop_rst(loop_rst), .bd_en(bd_en), .state(state), .mode_err(mode_err));
   always #5 clk = ~clk;
   task automatic tick(input int n);
      repeat (n) @(negedge clk);
   endtask
   task automatic test_reset;
      #12;
      @(negedge clk);
      want = V_RESET; n_cmp++;
      if (obs !== want) begin n_bad++; $display("FAIL reset_values: got %h want %h", obs, want); end
      rst = 1'b0;
      tick(1);
      want = V_SET_B; n_cmp++;
      if (obs !== want) begin n_bad++; $display("FAIL first_edge_settle: got %h want %h", obs, want); end
   endtask
   task automatic test_settle_lock;
      tick(255);
      want = V_SET_B; n_cmp++;
      if (obs !== want) begin n_bad++; $display("FAIL settle_last_cycle: got %h want %h", obs, want); end
      tick(1);
      want = V_ACQ_B; n_cmp++;
      if (obs !== want) begin n_bad++; $display("FAIL acq_entry: got %h want %h", obs, want); end
      tick(64);
      want = V_ACQ_B; n_cmp++;
      if (obs !== want) begin n_bad++; $display("FAIL acq_before_lock: got %h want %h", obs, want); end
      tick(1);
      want = V_TRK_B; n_cmp++;
      if (obs !== want) begin n_bad++; $display("FAIL track_entry: got %h want %h", obs, want); end
   endtask
   task automatic test_invalid_mode;
      mode_req = 4'b0011; mode_req_vld = 1'b1;
      tick(1);
      mode_req_vld = 1'b0;
      want = V_TRK_ERR; n_cmp++;
      if (obs !== want) begin n_bad++; $display("FAIL invalid_mode_pulse: got %h want %h", obs, want); end
      tick(1);
      want = V_TRK_B; n_cmp++;
      if (obs !== want) begin n_bad++; $display("FAIL invalid_mode_after: got %h want %h", obs, want); end
   endtask
   task automatic test_loss;
      pd_lock = 1'b0;
      tick(127);
      want = V_TRK_B; n_cmp++;
      if (obs !== want) begin n_bad++; $display("FAIL loss_127_low: got %h want %h", obs, want); end
      pd_lock = 1'b1;
      tick(2);
      want = V_TRK_B; n_cmp++;
      if (obs !== want) begin n_bad++; $display("FAIL loss_recovered: got %h want %h", obs, want); end
      pd_lock = 1'b0;
      tick(128);
      want = V_TRK_B; n_cmp++;
      if (obs !== want) begin n_bad++; $display("FAIL loss_128_low: got %h want %h", obs, want); end
      tick(1);
      want = V_ACQ_B; n_cmp++;
      if (obs !== want) begin n_bad++; $display("FAIL loss_to_acq: got %h want %h", obs, want); end
   endtask
   task automatic test_timeouts;
      for (int i = 0; i < 4; i++) begin
         tick(16383);
         want = V_ACQ_B; n_cmp++;
         if (obs !== want) begin n_bad++; $display("FAIL timeout_%0d_before: got %h want %h", i, obs, want); end
         tick(1);
         want = i < 3 ? V_SET_B : V_FAIL_B; n_cmp++;
         if (obs !== want) begin n_bad++; $display("FAIL timeout_%0d_after: got %h want %h", i, obs, want); end
         if (i < 3) begin
            tick(256);
            want = V_ACQ_B; n_cmp++;
            if (obs !== want) begin n_bad++; $display("FAIL retry_%0d_acq: got %h want %h", i, obs, want); end
         end
      end
      tick(3);
      want = V_FAIL_B; n_cmp++;
      if (obs !== want) begin n_bad++; $display("FAIL fail_hold: got %h want %h", obs, want); end
   endtask
   task automatic test_mode_from_fail;
      mode_req = 4'b0010; mode_req_vld = 1'b1;
      tick(1);
      want = V_SET_Q; n_cmp++;
      if (obs !== want) begin n_bad++; $display("FAIL fail_to_settle_qpsk: got %h want %h", obs, want); end
      mode_req = 4'b0001;
      tick(255);
      want = V_SET_Q; n_cmp++;
      if (obs !== want) begin n_bad++; $display("FAIL settle_blocks_req: got %h want %h", obs, want); end
      tick(1);
      want = V_ACQ_Q; n_cmp++;
      if (obs !== want) begin n_bad++; $display("FAIL req_pending_acq: got %h want %h", obs, want); end
      tick(1);
      mode_req_vld = 1'b0;
      want = V_SET_B; n_cmp++;
      if (obs !== want) begin n_bad++; $display("FAIL req_accepted_in_acq: got %h want %h", obs, want); end
      tick(256);
      want = V_ACQ_B; n_cmp++;
      if (obs !== want) begin n_bad++; $display("FAIL back_to_acq: got %h want %h", obs, want); end
   endtask
   task automatic test_sigloss_with_req;
      sig_det = 1'b0; mode_req = 4'b0100; mode_req_vld = 1'b1;
      tick(1);
      mode_req_vld = 1'b0;
      want = V_IDLE_M; n_cmp++;
      if (obs !== want) begin n_bad++; $display("FAIL sigloss_req_idle: got %h want %h", obs, want); end
      tick(2);
      want = V_IDLE_M; n_cmp++;
      if (obs !== want) begin n_bad++; $display("FAIL idle_hold: got %h want %h", obs, want); end
   endtask
   task automatic test_async_reset;
      sig_det = 1'b1; pd_lock = 1'b1;
      tick(1);
      want = V_SET_M; n_cmp++;
      if (obs !== want) begin n_bad++; $display("FAIL reacquire_settle: got %h want %h", obs, want); end
      tick(256 + 65);
      want = V_TRK_M; n_cmp++;
      if (obs !== want) begin n_bad++; $display("FAIL reacquire_track: got %h want %h", obs, want); end
      #2 rst = 1'b1;
      #1;
      want = V_RESET; n_cmp++;
      if (obs !== want) begin n_bad++; $display("FAIL async_reset: got %h want %h", obs, want); end
      @(negedge clk);
      rst = 1'b0;
   endtask
   initial begin
      test_reset;
      test_settle_lock;
      test_invalid_mode;
      test_loss;
      test_timeouts;
      test_mode_from_fail;
      test_sigloss_with_req;
      test_async_reset;
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule

// File: doc/rx_acq_ctrl.md
# rx_acq_ctrl

Acquisition and tracking sequencer for the PSK receive chain, in the 16.384 MHz domain. It owns the Rx configuration: MODE_CTRL, FEEDBACK_SHIFT and GARDNER_SHIFT. It holds the carrier and timing loops in reset until a signal is detected, then runs them at wide bandwidth until lock and switches them to narrow bandwidth for tracking. It gates the bit decisions and re-acquires on lock loss, mode change or signal drop.

## Interface
Parameters:
- SETTLE_CYC, 256: cycles loop_rst is held after entering SETTLE.
- LOCK_CNT, 64: consecutive pd_lock-high cycles that declare lock.
- LOSS_CNT, 128: consecutive pd_lock-low cycles in TRACK that declare loss.
- ACQ_TIMEOUT, 16384: maximum cycles in ACQ per attempt.
- MAX_RETRY, 3: ACQ timeouts allowed before FAIL.
- ACQ_SHIFT, 2: FEEDBACK/GARDNER shift during ACQ (wide bandwidth).
- TRK_SHIFT, 4: shift during TRACK (narrow bandwidth).

Ports:
- clk_16M384, in, 1: sole clock.
- rst_16M384, in, 1: reset, asynchronous, active-high.
- mode_req, in, 4: requested mode; one-hot BPSK 4'b0001, QPSK 4'b0010, MIX 4'b0100.
- mode_req_vld, in, 1: request valid.
- mode_req_rdy, out, 1: request accepted when vld && rdy.
- sig_det, in, 1: signal-detect from Rx (window/threshold detector).
- pd_lock, in, 1: phase-detector lock indication.
- MODE_CTRL, out, 4: active mode to Rx.
- FEEDBACK_SHIFT, out, 4: carrier-loop gain shift.
- GARDNER_SHIFT, out, 4: timing-loop gain shift.
- loop_rst, out, 1: synchronous reset to the Rx loops.
- bd_en, out, 1: bit-decision enable.
- state, out, 3: IDLE=0, SETTLE=1, ACQ=2, TRACK=3, FAIL=4.
- mode_err, out, 1: one-cycle pulse when a non-one-hot or unsupported mode is offered.

## Operation
- Reset values:
  - state=IDLE, MODE_CTRL=4'b0001
  - FEEDBACK_SHIFT=GARDNER_SHIFT=ACQ_SHIFT
  - loop_rst=1, bd_en=0, mode_req_rdy=1, mode_err=0
  - all counters 0
- IDLE:
  - loop_rst=1, bd_en=0.
  - sig_det=1 → SETTLE; retry counter cleared.
- SETTLE:
  - loop_rst=1; shifts=ACQ_SHIFT.
  - After SETTLE_CYC cycles → ACQ.
  - mode_req_rdy=0 in this state only.
- ACQ:
  - loop_rst=0, shifts=ACQ_SHIFT, bd_en=0.
  - Lock counter increments while pd_lock=1 and clears on pd_lock=0.
  - Reaching LOCK_CNT → TRACK.
  - Attempt timer reaching ACQ_TIMEOUT → retry+1. If retry<MAX_RETRY → SETTLE, else → FAIL.
- TRACK:
  - loop_rst=0, shifts=TRK_SHIFT, bd_en=1.
  - Loss counter increments while pd_lock=0 and clears on pd_lock=1.
  - Reaching LOSS_CNT → ACQ with the timer cleared; retry count is not cleared.
- FAIL:
  - loop_rst=1, bd_en=0.
  - Left only by an accepted mode request (→ SETTLE, retry cleared) or by sig_det=0 (→ IDLE).
- Mode request:
  - Accepted in any state except SETTLE. Valid one-hot → MODE_CTRL updated and → SETTLE (from IDLE only if sig_det=1; otherwise it stays IDLE with the new mode).
  - Invalid code: consumed (rdy handshake completes), mode_err pulses, MODE_CTRL and state unchanged.
  - Re-requesting the current mode still restarts SETTLE.
- Priority, highest first: sig_det=0 (→ IDLE from every state) > accepted valid mode request > lock/loss/timeout conditions.

## Timing
- All outputs are registered.
- A condition sampled at edge n gives the new state and the outputs at edge n+1.
- MODE_CTRL changes on the same edge that state enters SETTLE. loop_rst is therefore already 1 when the Rx sees the new mode.
- loop_rst is high for exactly SETTLE_CYC cycles in SETTLE. ACQ is entered at edge SETTLE_CYC after SETTLE entry.
- TRACK is entered LOCK_CNT+1 edges after pd_lock rises in ACQ, if it stays high.
- Counters saturate and never wrap. The counter width is clog2 of the largest parameter plus 1.
- sig_det falling while in SETTLE: → IDLE on the next edge, and the settle counter is cleared.
- Reset asserted mid-operation: everything returns to reset values asynchronously. Release is synchronised by the top-level reset logic.

## Structure
- Shared package rx_ctrl_pkg:
  - mode one-hot constants MODE_BPSK, MODE_QPSK, MODE_MIX
  - state encoding
  - function is_valid_mode
- One sub-module, sat_counter: parameterised width, with inc, clr and terminal-count flag. Instantiated for the settle, lock, loss, timeout and retry counts.
- The FSM and output registers live in rx_acq_ctrl.

## Test plan
- Reset release with sig_det=1 and pd_lock=1: IDLE→SETTLE at the first edge, loop_rst high for 256 cycles, ACQ, then TRACK after 65 more edges. TRACK gives FEEDBACK_SHIFT=4 and bd_en=1.
- ACQ with pd_lock=0 throughout: three timeouts of 16384 cycles, each followed by a SETTLE. The fourth timeout goes to FAIL (state=4, loop_rst=1). Then mode_req=4'b0010 → SETTLE with MODE_CTRL=4'b0010.
- In TRACK, pd_lock low for 127 cycles then high: stays in TRACK. Low for 128 cycles: → ACQ, bd_en=0, shifts=2.
- mode_req=4'b0011 with vld in TRACK: mode_err pulses for 1 cycle, MODE_CTRL stays 4'b0001, state stays TRACK. mode_req offered during SETTLE: rdy=0 and not accepted until ACQ.
- sig_det falls in the same cycle as a valid mode_req=4'b0100 in ACQ: → IDLE, MODE_CTRL=4'b0100, loop_rst=1.
- rst_16M384 pulsed mid-TRACK, between clock edges: outputs go to reset values immediately, without waiting for a clock edge.
